// File: rtl/reg_file.sv
// reg_file: general-purpose register file for the simple-MIPS datapath.
// Two combinational read ports (rs, rt) and one synchronous write port.
// Register 0 is hardwired to zero. Reset is asynchronous, active-low.
// Optional macro REGFILE_BYPASS_EN: when defined, a same-cycle write to a
// register being read is forwarded to the read port (write-first);
// when undefined, reads return the old contents until the edge (read-first).
module reg_file #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam int RD_PORTS = 2;

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];

    // Next-state: load the addressed register on a write; register 0 stays zero
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    // Register array: asynchronous clear dominates any write in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports share one structure; index 0 is rs, index 1 is rt
    logic [ADDR_W-1:0] rd_addr [RD_PORTS];
    logic [DATA_W-1:0] rd_data [RD_PORTS];

    assign rd_addr[0] = rs_addr;
    assign rd_addr[1] = rt_addr;

    genvar gi;
    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            // Forwarding is suppressed in reset so outputs stay at zero,
            // and address 0 never forwards.
            logic bypass_hit;
            assign bypass_hit = BYPASS && rst_n && wr_en &&
                                (wr_addr == rd_addr[gi]) && (rd_addr[gi] != '0);
            assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                                 bypass_hit          ? wr_data :
                                                       regs_q[rd_addr[gi]];
        end
    endgenerate

    assign rs_data = rd_data[0];
    assign rt_data = rd_data[1];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized and directed self-checking bench for reg_file.
// The reference model is a plain array of register values plus a read
// function that applies the zero-register and collision rules.
module tb_reg_file;

    localparam int DATA_W  = 32;
    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model [REG_NUM];

    reg_file #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected combinational read value for the current inputs
    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (!rst_n) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < REG_NUM; i++) model[i] = '0;
    endtask

    // One write transaction: drive at negedge, commit at posedge, drop wr_en
    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
        if (rst_n && a != 0) model[a] = d;
        $display("write r%0d = %h", a, d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        // power-on reset state: every address reads 0
        for (int i = 0; i < REG_NUM; i++) begin
            rs_addr = ADDR_W'(i); rt_addr = ADDR_W'(REG_NUM - 1 - i);
            #1;
            checks++;
            if (rs_data !== '0 || rt_data !== '0) begin
                $display("FAIL por_zero addr=%0d rs=%h rt=%h required 0", i, rs_data, rt_data);
                errors++;
            end
        end
        write_reg(5, 32'h0000_1234);
        rs_addr = 5; #1;
        checks++;
        if (rs_data !== 32'h0000_1234) begin
            $display("FAIL pre_reset_r5 got %h required 00001234", rs_data);
            errors++;
        end
        // assert reset mid-cycle, check immediately with no clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (rs_data !== '0) begin
            $display("FAIL async_reset_r5 got %h required 0", rs_data);
            errors++;
        end
        $display("reset asserted mid-cycle, r5 reads %h", rs_data);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < REG_NUM; i++) begin
            rs_addr = ADDR_W'(i); rt_addr = ADDR_W'(i);
            #1;
            checks++;
            if (rs_data !== '0 || rt_data !== '0) begin
                $display("FAIL after_reset addr=%0d rs=%h rt=%h required 0", i, rs_data, rt_data);
                errors++;
            end
        end
    endtask

    task automatic test_basic();
        write_reg(3, 32'hDEAD_BEEF);
        write_reg(31, 32'h0000_0001);
        rs_addr = 3; rt_addr = 31; #1;
        checks++;
        if (rs_data !== 32'hDEAD_BEEF) begin
            $display("FAIL basic_rs got %h required deadbeef", rs_data);
            errors++;
        end
        checks++;
        if (rt_data !== 32'h0000_0001) begin
            $display("FAIL basic_rt got %h required 00000001", rt_data);
            errors++;
        end
        rs_addr = 31; rt_addr = 31; #1;
        checks++;
        if (rs_data !== rt_data || rs_data !== 32'h0000_0001) begin
            $display("FAIL same_addr rs=%h rt=%h required 00000001", rs_data, rt_data);
            errors++;
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
        rs_addr = 0; rt_addr = 0; #1;
        checks++;
        if (rs_data !== '0 || rt_data !== '0) begin
            $display("FAIL zero_in_cycle rs=%h rt=%h required 0", rs_data, rt_data);
            errors++;
        end
        @(posedge clk); #1;
        @(negedge clk); wr_en = 1'b0; #1;
        checks++;
        if (rs_data !== '0 || rt_data !== '0) begin
            $display("FAIL zero_after rs=%h rt=%h required 0", rs_data, rt_data);
            errors++;
        end
        $display("write r0 = ffffffff ignored, reads %h/%h", rs_data, rt_data);
    endtask

    task automatic test_wr_en();
        write_reg(7, 32'h0000_0055);
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 7; wr_data = 32'h0000_00AA; rs_addr = 7; rt_addr = 7;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rs_data !== 32'h0000_0055 || rt_data !== 32'h0000_0055) begin
            $display("FAIL wr_en_gate rs=%h rt=%h required 00000055", rs_data, rt_data);
            errors++;
        end
        $display("wr_en=0 for 3 cycles, r7 reads %h", rs_data);
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'h0000_0020;
`else
        exp_pre = 32'h0000_0010;
`endif
        write_reg(9, 32'h0000_0010);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h0000_0020; rs_addr = 9; rt_addr = 9;
        #1;
        checks++;
        if (rs_data !== exp_pre || rt_data !== exp_pre) begin
            $display("FAIL collision_pre rs=%h rt=%h required %h", rs_data, rt_data, exp_pre);
            errors++;
        end
        @(posedge clk); #1;
        model[9] = 32'h0000_0020;
        @(negedge clk); wr_en = 1'b0; #1;
        checks++;
        if (rs_data !== 32'h0000_0020 || rt_data !== 32'h0000_0020) begin
            $display("FAIL collision_post rs=%h rt=%h required 00000020", rs_data, rt_data);
            errors++;
        end
        $display("collision r9: pre=%h post=%h", exp_pre, rs_data);
    endtask

    task automatic test_reset_during_write();
        write_reg(4, 32'h0000_0099);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h0000_0077; rs_addr = 4; rt_addr = 5;
        #3 rst_n = 1'b0;
        @(posedge clk);
        #2;
        model_clear();
        rst_n = 1'b1; wr_en = 1'b0;
        #1;
        checks++;
        if (rs_data !== '0) begin
            $display("FAIL reset_write_r4 got %h required 0", rs_data);
            errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (rs_data !== '0) begin
            $display("FAIL reset_write_r4_later got %h required 0", rs_data);
            errors++;
        end
        $display("reset across write edge, r4 reads %h", rs_data);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] e_rs;
        logic [DATA_W-1:0] e_rt;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = ADDR_W'($urandom_range(0, 7));
            wr_data = $urandom;
            rs_addr = ADDR_W'($urandom_range(0, 7));
            rt_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
            #1;
            e_rs = exp_read(rs_addr);
            e_rt = exp_read(rt_addr);
            checks++;
            if (rs_data !== e_rs) begin
                $display("FAIL rand_rs txn=%0d addr=%0d got %h required %h", n, rs_addr, rs_data, e_rs);
                errors++;
            end
            checks++;
            if (rt_data !== e_rt) begin
                $display("FAIL rand_rt txn=%0d addr=%0d got %h required %h", n, rt_addr, rt_data, e_rt);
                errors++;
            end
            $display("txn %0d we=%0d wa=%0d wd=%h rs=%0d:%h rt=%0d:%h",
                     n, wr_en, wr_addr, wr_data, rs_addr, rs_data, rt_addr, rt_data);
            @(posedge clk); #1;
            if (wr_en && wr_addr != 0) model[wr_addr] = wr_data;
        end
        @(negedge clk);
        wr_en = 1'b0;
        // sweep every register after the random run
        for (int i = 0; i < REG_NUM; i++) begin
            rs_addr = ADDR_W'(i); #1;
            checks++;
            if (rs_data !== model[i]) begin
                $display("FAIL sweep addr=%0d got %h required %h", i, rs_data, model[i]);
                errors++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rs_addr = '0; rt_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        test_reset();
        test_basic();
        test_zero();
        test_wr_en();
        test_collision();
        test_reset_during_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
